// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module  : button_pkg
// Brief   : Shared FSM state encoding and defaults for the button arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package button_pkg;

    localparam int DEFAULT_NUM_BTN = 4;
    localparam int WAIT_W          = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_GAP  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/press_detect.sv
`default_nettype none
// ============================================================================
// Module  : press_detect
// Brief   : Registered falling-edge detector for one active-low button level.
// Revision: 1.0 - initial release
// ============================================================================
module press_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    logic prev;
    logic armed;

    // A button held low across reset stays disarmed until it is seen released,
    // so it cannot masquerade as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= 1'b1;
            armed <= btn_n;
            press <= 1'b0;
        end else begin
            prev  <= btn_n;
            armed <= armed | btn_n;
            press <= armed & prev & ~btn_n;
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : button_arbiter
// Brief   : Round-robin arbiter turning button presses into ack'ed requests,
//           with per-button toggle state and an ack timeout.
// Revision: 1.0 - initial release
// ============================================================================
module button_arbiter
    import button_pkg::*;
#(
    parameter int NUM_BTN     = DEFAULT_NUM_BTN,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_BTN-1:0]         btn_n,
    input  logic                       ack,
    output logic                       req_valid,
    output logic [$clog2(NUM_BTN)-1:0] req_id,
    output logic [NUM_BTN-1:0]         lock_state,
    output logic [NUM_BTN-1:0]         pending,
    output logic                       timeout
);

    localparam int ID_W = $clog2(NUM_BTN);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [NUM_BTN-1:0] press;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   next_ptr;
    logic [ID_W-1:0]   sel_id;
    logic              sel_found;
    logic [ID_W:0]     cand;
    logic [WAIT_W-1:0] wait_cnt;
    logic [NUM_BTN-1:0] id_onehot;
    logic              accept;
    logic              expire;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_press
        press_detect u_press (
            .clk   (clk),
            .rst   (rst),
            .btn_n (btn_n[i]),
            .press (press[i])
        );
    end

    assign accept = (state == ST_REQ) && ack;
    assign expire = (state == ST_REQ) && !ack
                    && (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1));

    // Round-robin search starting at rr_ptr, wrapping at NUM_BTN.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_BTN; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_BTN)) begin
                cand = cand - (ID_W+1)'(NUM_BTN);
            end
            if (!sel_found && pending[cand[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        id_onehot         = '0;
        id_onehot[req_id] = 1'b1;
    end

    assign next_ptr = (req_id == ID_W'(NUM_BTN - 1)) ? '0 : req_id + 1'b1;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (|pending) state_next = ST_REQ;
            ST_REQ:  if (accept || expire) state_next = ST_GAP;
            ST_GAP:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_valid = (state == ST_REQ);
    end

    // Datapath: a new press wins over the clear of an accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            lock_state <= '0;
            req_id     <= '0;
            rr_ptr     <= '0;
            wait_cnt   <= '0;
            timeout    <= 1'b0;
        end else begin
            pending <= (pending & ~(accept ? id_onehot : '0)) | press;
            timeout <= expire;
            if (state == ST_IDLE && sel_found) begin
                req_id   <= sel_id;
                wait_cnt <= '0;
            end
            if (state == ST_REQ && !accept && !expire) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (accept) begin
                lock_state <= lock_state ^ id_onehot;
            end
            if (accept || expire) begin
                rr_ptr <= next_ptr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_arbiter
// Brief   : Directed self-checking bench for button_arbiter (4 buttons, timeout 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] btn_n;
    logic       ack;
    logic       req_valid;
    logic [1:0] req_id;
    logic [3:0] lock_state;
    logic [3:0] pending;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    button_arbiter #(
        .NUM_BTN     (4),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .ack        (ack),
        .req_valid  (req_valid),
        .req_id     (req_id),
        .lock_state (lock_state),
        .pending    (pending),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        btn_n = 4'hF;
        ack   = 1'b0;
        do_reset();
        check("rst_valid",   32'(req_valid),  0);
        check("rst_id",      32'(req_id),     0);
        check("rst_lock",    32'(lock_state), 0);
        check("rst_pending", 32'(pending),    0);
        check("rst_timeout", 32'(timeout),    0);

        // Single press on button 2, ack held high
        tick();
        ack   = 1'b1;
        btn_n = 4'b1011;
        tick();
        check("p2_e0_pending", 32'(pending),   0);
        tick();
        check("p2_e1_pending", 32'(pending),   'h4);
        check("p2_e1_valid",   32'(req_valid), 0);
        tick();
        check("p2_e2_valid",   32'(req_valid), 1);
        check("p2_e2_id",      32'(req_id),    2);
        tick();
        check("p2_e3_valid",   32'(req_valid),  0);
        check("p2_e3_lock",    32'(lock_state), 'h4);
        check("p2_e3_pending", 32'(pending),    0);
        tick();
        tick();
        check("p2_hold_pending", 32'(pending), 0);
        btn_n = 4'hF;
        tick();
        tick();

        // Buttons 0 and 3 together from rr_ptr=0
        do_reset();
        ack   = 1'b1;
        btn_n = 4'b0110;
        tick();
        tick();
        check("p03_pending", 32'(pending), 'h9);
        tick();
        check("p03_g0_valid", 32'(req_valid), 1);
        check("p03_g0_id",    32'(req_id),    0);
        tick();
        check("p03_gap_valid", 32'(req_valid), 0);
        tick();
        check("p03_idle_valid", 32'(req_valid), 0);
        tick();
        check("p03_g3_valid", 32'(req_valid), 1);
        check("p03_g3_id",    32'(req_id),    3);
        tick();
        check("p03_lock",    32'(lock_state), 'h9);
        check("p03_pending", 32'(pending),    0);
        btn_n = 4'hF;
        tick();
        tick();

        // Grant to 1 with a coincident re-press of 1, then round-robin to 0
        ack   = 1'b0;
        btn_n = 4'b1101;
        tick();
        btn_n = 4'b1100;
        tick();
        tick();
        check("rr_g1_valid",   32'(req_valid), 1);
        check("rr_g1_id",      32'(req_id),    1);
        check("rr_g1_pending", 32'(pending),   'h3);
        btn_n = 4'b1110;
        tick();
        btn_n = 4'b1100;
        tick();
        ack = 1'b1;
        tick();
        check("co_valid",   32'(req_valid),  0);
        check("co_lock",    32'(lock_state), 'hB);
        check("co_pending", 32'(pending),    'h3);
        tick();
        tick();
        check("rr_wrap_valid", 32'(req_valid), 1);
        check("rr_wrap_id",    32'(req_id),    0);
        tick();
        tick();
        tick();
        check("co_regrant_valid", 32'(req_valid), 1);
        check("co_regrant_id",    32'(req_id),    1);
        tick();
        check("co_end_lock",    32'(lock_state), 'h8);
        check("co_end_pending", 32'(pending),    0);
        btn_n = 4'hF;
        tick();
        tick();

        // Timeout on button 2 with ack low
        ack   = 1'b0;
        btn_n = 4'b1011;
        tick();
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("to_valid_%0d", c), 32'(req_valid), 1);
            check($sformatf("to_nopulse_%0d", c), 32'(timeout), 0);
        end
        tick();
        check("to_pulse",   32'(timeout),    1);
        check("to_valid",   32'(req_valid),  0);
        check("to_pending", 32'(pending),    'h4);
        check("to_lock",    32'(lock_state), 'h8);
        tick();
        check("to_pulse_end", 32'(timeout), 0);
        ack = 1'b1;
        tick();
        check("to_reissue_valid", 32'(req_valid), 1);
        check("to_reissue_id",    32'(req_id),    2);
        tick();
        check("to_accept_lock", 32'(lock_state), 'hC);
        btn_n = 4'hF;
        tick();
        tick();

        // Reset mid-request with button 0 held through reset release
        ack   = 1'b0;
        btn_n = 4'b1110;
        tick();
        tick();
        tick();
        check("mr_valid", 32'(req_valid), 1);
        rst = 1'b1;
        tick();
        check("mr_rst_valid",   32'(req_valid),  0);
        check("mr_rst_id",      32'(req_id),     0);
        check("mr_rst_lock",    32'(lock_state), 0);
        check("mr_rst_pending", 32'(pending),    0);
        check("mr_rst_timeout", 32'(timeout),    0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("mr_held_valid_%0d", c), 32'(req_valid), 0);
        end
        check("mr_held_pending", 32'(pending), 0);
        btn_n = 4'hF;
        tick();
        btn_n = 4'b1110;
        tick();
        tick();
        check("mr_repress_pending", 32'(pending), 'h1);
        tick();
        check("mr_repress_valid", 32'(req_valid), 1);
        check("mr_repress_id",    32'(req_id),    0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_arbiter.md
BUTTON_ARBITER -- requirements
Module: button_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_BTN, default 4, giving the number of buttons (2..8).
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 255, giving the maximum wait cycles for ack (1..255).
REQ-003 Port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port btn_n, input, NUM_BTN, raw button levels, active-low (0 = pressed), already synchronous to clk.
REQ-006 Port ack, input, 1, downstream accepts the current request.
REQ-007 Port req_valid, output, 1, a request is presented.
REQ-008 Port req_id, output, $clog2(NUM_BTN), index of the button being served.
REQ-009 Port lock_state, output, NUM_BTN, per-button toggle state; each bit flips once per accepted request.
REQ-010 Port pending, output, NUM_BTN, presses detected but not yet accepted.
REQ-011 Port timeout, output, 1, one-cycle pulse when a request is abandoned.

Function
REQ-012 A press SHALL be a 1->0 transition of btn_n[i] between consecutive clk samples; holding the button low SHALL NOT generate further presses.
REQ-013 A press SHALL set pending[i] on the next edge; a press while pending[i]=1 SHALL be coalesced (no counting).
REQ-014 The FSM states SHALL be IDLE, REQ and GAP.
REQ-015 IDLE: if pending != 0, select the first set bit searching round-robin from pointer rr_ptr (wrapping NUM_BTN-1 -> 0), latch it into req_id, go to REQ; otherwise stay.
REQ-016 REQ: req_valid=1 and req_id SHALL be stable until acceptance or timeout.
REQ-017 Acceptance SHALL be req_valid=1 and ack=1 on the same edge; then clear pending[req_id], flip lock_state[req_id], set rr_ptr=req_id+1 (mod NUM_BTN), and go to GAP.
REQ-018 GAP SHALL last exactly one cycle with req_valid=0, then go to IDLE; back-to-back grants are therefore spaced by at least 2 idle cycles.
REQ-019 Each REQ SHALL have a wait counter starting at 0; if it reaches ACK_TIMEOUT without ack: pulse timeout, keep pending[req_id] set, set rr_ptr=req_id+1, go to GAP, and leave lock_state unchanged.
REQ-020 A new press on button req_id in the same cycle as its acceptance SHALL leave pending[req_id]=1 (set wins over clear).
REQ-021 ack outside REQ SHALL be ignored.
REQ-022 Latency: a press at edge N with the FSM in IDLE and no other pending SHALL give req_valid=1 at edge N+2.

Reset
REQ-023 While rst=1 at an edge: state=IDLE, req_valid=0, req_id=0, lock_state=0, pending=0, timeout=0, rr_ptr=0, wait counter=0, and the previous-sample register for btn_n = all ones (released).
REQ-024 Reset mid-REQ SHALL abandon the request without a timeout pulse or lock_state change.
REQ-025 A button held low through reset release SHALL NOT register a press until it is released and pressed again.

Structure
REQ-026 Shared package button_pkg SHALL hold the FSM state encoding (IDLE=2'b00, REQ=2'b01, GAP=2'b11) and the default NUM_BTN.
REQ-027 Sub-module press_detect (one per button: prev register plus falling-edge pulse) SHALL be instantiated NUM_BTN times via generate.

Verification
REQ-028 Single press btn_n[2] 1->0, ack held 1 -> req_valid at +2 cycles with req_id=2 for one cycle, then lock_state=4'b0100 and pending=0.
REQ-029 Buttons 0 and 3 pressed in the same cycle, rr_ptr=0, ack=1 -> grants 0 then 3, separated by GAP; lock_state=4'b1001.
REQ-030 Round-robin: after a grant to 1, with pending=4'b0011 -> next grant is 0 (wrap from rr_ptr=2), not 1.
REQ-031 ack=0, ACK_TIMEOUT=4 -> req_valid high for 4 cycles, timeout pulse, pending bit still set, lock_state unchanged, request reissued later.
REQ-032 Press button 1 in the same cycle its request is accepted -> lock_state[1] flips, pending[1] stays 1, a second grant for button 1 follows.
REQ-033 rst asserted during REQ with btn_n[0] held low, then released -> all outputs 0, no grant until btn_n[0] goes 1 then 0.
